// File: rtl/tabulate_sweep_ctrl_if.sv
// Datapath bundle between the sweep sequencer and the shared passthrough.
// The master issues words and a valid strobe; the slave returns the result.
interface tabulate_sweep_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] dp_in;
    logic              dp_valid;
    logic [DATA_W-1:0] dp_out;

    modport master (output dp_in, output dp_valid, input dp_out);
    modport slave  (input dp_in, input dp_valid, output dp_out);
endinterface

// File: rtl/tabulate_sweep_ctrl.sv
// Row-major sweep sequencer for a shared passthrough datapath.
// It issues BASE+i+j per point, checks the return after LATENCY cycles, and logs errors.
module tabulate_sweep_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int BASE    = 1,
    parameter int LATENCY = 1,
    parameter int ERR_W   = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    tabulate_sweep_ctrl_if.master dp,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_W-1:0]      err_count_o,
    output logic                  fail_valid_o,
    output logic [RW-1:0]         fail_row_o,
    output logic [CW-1:0]         fail_col_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fv_q, fv_d;
    logic [RW-1:0]     fr_q, fr_d;
    logic [CW-1:0]     fc_q, fc_d;
    logic [DATA_W-1:0] val;

    // Wraps at DATA_W bits by construction.
    assign val = DATA_W'(BASE) + DATA_W'(i_q) + DATA_W'(j_q);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fr_d    = fr_q;
        fc_d    = fc_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fr_d    = '0;
                    fc_d    = '0;
                end
            end
            ISSUE: begin
                din_d   = val;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LW'(LATENCY - 1)) begin
                    if (dp.dp_out != din_q) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fv_q) begin
                            fv_d = 1'b1;
                            fr_d = i_q;
                            fc_d = j_q;
                        end
                    end
                    if (j_q != CW'(COLS - 1)) begin
                        j_d     = j_q + 1'b1;
                        state_d = ISSUE;
                    end else if (i_q != RW'(ROWS - 1)) begin
                        j_d     = '0;
                        i_d     = i_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fr_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fr_q    <= fr_d;
            fc_q    <= fc_d;
        end
    end

    assign dp.dp_in     = (state_q == ISSUE) ? val : din_q;
    assign dp.dp_valid  = (state_q == ISSUE);
    assign busy_o       = (state_q == ISSUE) || (state_q == WAIT);
    assign done_o       = (state_q == DONE);
    assign pass_o       = done_o && (err_q == '0);
    assign err_count_o  = err_q;
    assign fail_valid_o = fv_q;
    assign fail_row_o   = fr_q;
    assign fail_col_o   = fc_q;
endmodule

// File: doc/tabulate_sweep_ctrl.md
Name: tabulate_sweep_ctrl

Overview:
Sequencer that drives a shared DATA_W-bit passthrough datapath through a ROWS x COLS sweep. At each grid point (i,j) it issues the expected value BASE+i+j, waits the datapath latency, and compares the returned word. It counts mismatches and records the first failing coordinate. It replaces per-point hard-wired passthrough instances and assertions with one time-multiplexed datapath plus a self-checking controller.

Parameters:
DATA_W, 32, datapath word width
ROWS, 2, outer index count (i), >=1
COLS, 2, inner index count (j), >=1
BASE, 1, value offset; expected(i,j) = (BASE+i+j) mod 2^DATA_W
LATENCY, 1, cycles from issue to valid dp_out, >=1
ERR_W, 16, error counter width

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins sweep when not busy
dp_in  out  DATA_W  word driven into shared datapath
dp_valid  out  1  high only in the ISSUE cycle of each point
dp_out  in  DATA_W  word returned by datapath
busy  out  1  high in ISSUE/WAIT
done  out  1  high in DONE
pass  out  1  done && err_count==0
err_count  out  ERR_W  mismatch count, saturating
fail_valid  out  1  a first failure has been captured
fail_row  out  clog2(ROWS) max 1  i of first mismatch
fail_col  out  clog2(COLS) max 1  j of first mismatch

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock and reset ports are named clock and reset.
- Reset values: state=IDLE, i=j=0, wait counter=0, dp_in=0, dp_valid=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_row=0, fail_col=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE or DONE with start=1 -> ISSUE:
  - i=j=0; err_count, fail_* and done cleared on that edge.
- start while busy is ignored.
- ISSUE (1 cycle):
  - dp_in=BASE+i+j, dp_valid=1, wait counter<=0.
  - Next state is WAIT.
- WAIT (exactly LATENCY cycles):
  - dp_in held at the issued value; dp_valid=0.
  - On the final WAIT cycle (counter==LATENCY-1), dp_out is compared with the expected value.
- Mismatch handling:
  - err_count increments, saturating at 2^ERR_W-1.
  - If fail_valid=0, capture fail_row=i, fail_col=j, fail_valid=1.
  - Capture holds until the next start or reset.
- Index advance after the compare, row-major with j innermost:
  - j<COLS-1: j++ -> ISSUE.
  - j==COLS-1 and i<ROWS-1: j=0, i++ -> ISSUE.
  - Last point: -> DONE.
- Sweep order for 2x2: (0,0),(0,1),(1,0),(1,1).
- Each point takes 1+LATENCY cycles. The full sweep takes ROWS*COLS*(1+LATENCY) cycles from the first ISSUE to DONE entry.
- DONE:
  - done=1 and busy=0.
  - pass is combinational from done and err_count.
  - Results held until start or reset.
- Value arithmetic: computed at DATA_W bits and wraps modulo 2^DATA_W (BASE+i+j overflow is not an error).
- Reset mid-sweep: returns to IDLE on that edge, all outputs at reset values; a start pulse in the same cycle as reset is ignored.
- ROWS=COLS=1: a single point, then DONE.

Test Plan:
- Defaults, dp_out=dp_in (ideal passthrough), start pulse:
  - dp_valid pulses carry values 1,2,2,3 at cycles 1,3,5,7 after start.
  - done after 8 cycles; pass=1, err_count=0, fail_valid=0.
- Defaults, dp_out forced to 2 constant:
  - err_count=2 (points (0,0) and (1,1)).
  - fail_valid=1, fail_row=0, fail_col=0, pass=0.
- LATENCY=3, datapath = 3-stage register pipe:
  - pass=1; done after 16 cycles.
  - dp_in stable for 4 cycles per point.
- Reset asserted mid-WAIT of point (1,0):
  - next cycle all outputs at reset values.
  - a new start then completes with pass=1.
- start pulsed during busy:
  - sweep unaffected; same 8-cycle timing.
  - a second start while in DONE reruns the sweep and clears err_count.
- DATA_W=8, BASE=255, ROWS=COLS=2:
  - expected values 255,0,0,1 (wrap).
  - ideal passthrough gives pass=1.
